// File: rtl/saed32_2rw_bitmask_ram_if.sv
// One request/response port of the 2RW bit-mask RAM.
// A request is taken on a rising edge only when CE and RDY are both 1 at that edge; RDY is a registered output.
interface saed32_2rw_bitmask_ram_if #(
  parameter int WIDTH = 39,
  parameter int AW    = 5
);
  logic [AW-1:0]    A;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] WEM;
  logic             WE;
  logic             CE;
  logic             RDY;
  logic [WIDTH-1:0] Q;
  logic             QV;

  modport master (output A, D, WEM, WE, CE, input RDY, Q, QV);
  modport slave  (input A, D, WEM, WE, CE, output RDY, Q, QV);
endinterface

// File: rtl/saed32_2rw_bitmask_ram.sv
// Dual-port RAM with per-bit write masks over word-write storage.
// Partial-mask writes run as a 2-cycle read-modify-write; port 0 wins same-address write collisions.
module saed32_2rw_bitmask_ram #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 32
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  saed32_2rw_bitmask_ram_if.slave        p0,
  saed32_2rw_bitmask_ram_if.slave        p1,
  output logic [1:0]                     dbg_rmw_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic {ST_IDLE, ST_RMW} state_e;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    req_a   [2];
  logic [WIDTH-1:0] req_d   [2];
  logic [WIDTH-1:0] req_wem [2];
  logic [1:0]       req_we;
  logic [1:0]       req_ce;

  state_e           state_q    [2];
  logic [1:0]       rdy_q;
  logic [1:0]       qv_q;
  logic [WIDTH-1:0] q_q        [2];
  logic [AW-1:0]    addr_q     [2];
  logic [WIDTH-1:0] dat_q      [2];
  logic [WIDTH-1:0] msk_q      [2];
  logic [WIDTH-1:0] base_q     [2];
  logic [1:0]       fwd_q;
  logic [WIDTH-1:0] fwd_data_q [2];

  logic [1:0]       addr_ok;
  logic [1:0]       acc;
  logic [1:0]       rd;
  logic [1:0]       full_wr;
  logic [1:0]       part_wr;
  logic [1:0]       cmt;
  logic [AW-1:0]    cmt_addr [2];
  logic [WIDTH-1:0] cmt_data [2];
  logic [WIDTH-1:0] base_sel [2];
  logic [WIDTH-1:0] merged   [2];

  assign req_a[0]   = p0.A;
  assign req_a[1]   = p1.A;
  assign req_d[0]   = p0.D;
  assign req_d[1]   = p1.D;
  assign req_wem[0] = p0.WEM;
  assign req_wem[1] = p1.WEM;
  assign req_we     = {p1.WE, p0.WE};
  assign req_ce     = {p1.CE, p0.CE};

  assign p0.RDY = rdy_q[0];
  assign p1.RDY = rdy_q[1];
  assign p0.QV  = qv_q[0];
  assign p1.QV  = qv_q[1];
  assign p0.Q   = q_q[0];
  assign p1.Q   = q_q[1];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // Out-of-range addresses are dropped entirely, as if CE were low.
      addr_ok[p]  = ({1'b0, req_a[p]} < DEPTH_W);
      acc[p]      = RSTN & req_ce[p] & rdy_q[p] & addr_ok[p];
      rd[p]       = acc[p] & ~req_we[p];
      full_wr[p]  = acc[p] & req_we[p] & (&req_wem[p]);
      part_wr[p]  = acc[p] & req_we[p] & (|req_wem[p]) & ~(&req_wem[p]);
      base_sel[p] = fwd_q[p] ? fwd_data_q[p] : base_q[p];
      merged[p]   = (base_sel[p] & ~msk_q[p]) | (dat_q[p] & msk_q[p]);
      cmt[p]      = full_wr[p] | (state_q[p] == ST_RMW);
      cmt_addr[p] = (state_q[p] == ST_RMW) ? addr_q[p] : req_a[p];
      cmt_data[p] = (state_q[p] == ST_RMW) ? merged[p] : req_d[p];
    end
  end

  // Port 0 is written last so its word survives a same-address collision.
  always_ff @(posedge CLK) begin
    if (cmt[1]) mem[cmt_addr[1]] <= cmt_data[1];
    if (cmt[0]) mem[cmt_addr[0]] <= cmt_data[0];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int p = 0; p < 2; p++) begin
        state_q[p]    <= ST_IDLE;
        rdy_q[p]      <= 1'b1;
        qv_q[p]       <= 1'b0;
        q_q[p]        <= '0;
        addr_q[p]     <= '0;
        dat_q[p]      <= '0;
        msk_q[p]      <= '0;
        base_q[p]     <= '0;
        fwd_q[p]      <= 1'b0;
        fwd_data_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        qv_q[p] <= rd[p];
        if (rd[p]) q_q[p] <= mem[req_a[p]];
        case (state_q[p])
          ST_IDLE: begin
            if (part_wr[p]) begin
              state_q[p] <= ST_RMW;
              rdy_q[p]   <= 1'b0;
              addr_q[p]  <= req_a[p];
              dat_q[p]   <= req_d[p];
              msk_q[p]   <= req_wem[p];
              base_q[p]  <= mem[req_a[p]];
              // The storage read is pre-write; take the other port's word if it lands here now.
              fwd_q[p]      <= cmt[1-p] && (cmt_addr[1-p] == req_a[p]);
              fwd_data_q[p] <= cmt_data[1-p];
            end
          end
          ST_RMW: begin
            state_q[p] <= ST_IDLE;
            rdy_q[p]   <= 1'b1;
            fwd_q[p]   <= 1'b0;
          end
          default: begin
            state_q[p] <= ST_IDLE;
            rdy_q[p]   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign dbg_rmw_o = {state_q[1] == ST_RMW, state_q[0] == ST_RMW};
endmodule
